// File: rtl/double_to_int_arb_pkg.sv
// Shared definitions for the double_to_int round-robin arbiter.
//   WORD_W     : operand/result word width
//   OVERFLOW_Z : converter result for out-of-range or NaN operands
//   arb_state_t: sequencer states
package double_to_int_arb_pkg;

   localparam int unsigned WORD_W     = 64;
   localparam logic [63:0] OVERFLOW_Z = 64'h8000000000000000;

   typedef enum logic [2:0] {
      ARB    = 3'd0,
      GRANT  = 3'd1,
      SEND   = 3'd2,
      WAIT_Z = 3'd3,
      PUT_Z  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/double_to_int_rr_pick.sv
// Combinational round-robin pick.
//   req    : request vector, one bit per requester
//   rr_ptr : index holding highest priority
//   winner : first set bit at or above rr_ptr, wrapping to index 0
//   any    : at least one request bit set
module double_to_int_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   // First pass covers indices >= rr_ptr; anything still unclaimed lies
   // below rr_ptr, where the lowest index is the correct wrapped choice.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any && req[j] && (j >= 32'(rr_ptr))) begin
            any    = 1'b1;
            winner = IDX_W'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any && req[j]) begin
            any    = 1'b1;
            winner = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/double_to_int_arbiter.sv
// Round-robin arbiter sharing one double_to_int converter between NUM_REQ
// requesters using stb/ack handshakes. One conversion is in flight at a time.
//   clk, rst            : clock, synchronous active-low reset
//   req_a / req_a_stb   : packed operands and their valid bits
//   req_a_ack           : registered operand accept, one-hot to the grantee
//   req_z / req_z_stb   : broadcast result, valid one-hot to the grantee
//   req_z_ack           : result accept per requester
//   conv_a*/conv_z*     : handshake to the converter (its reset is ~rst)
//   grant_id            : current or last granted requester
//   busy                : high in every state except ARB
module double_to_int_arbiter
   import double_to_int_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WORD_W*NUM_REQ-1:0] req_a,
   input  logic [NUM_REQ-1:0]        req_a_stb,
   output logic [NUM_REQ-1:0]        req_a_ack,
   output logic [WORD_W-1:0]         req_z,
   output logic [NUM_REQ-1:0]        req_z_stb,
   input  logic [NUM_REQ-1:0]        req_z_ack,
   output logic [WORD_W-1:0]         conv_a,
   output logic                      conv_a_stb,
   input  logic                      conv_a_ack,
   input  logic [WORD_W-1:0]         conv_z,
   input  logic                      conv_z_stb,
   output logic                      conv_z_ack,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] a_ack_q, a_ack_nxt;
   logic [NUM_REQ-1:0] z_stb_q, z_stb_nxt;
   logic               ca_stb_q, ca_stb_nxt;
   logic               cz_ack_q, cz_ack_nxt;
   logic [IDX_W-1:0]   grant_q, grant_nxt;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_nxt;
   logic               busy_q;
   logic [WORD_W-1:0]  a_q, a_nxt;
   logic [WORD_W-1:0]  z_q, z_nxt;
   logic [WORD_W-1:0]  req_z_q, req_z_nxt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   double_to_int_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req_a_stb),
      .rr_ptr (rr_ptr_q),
      .winner (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_nxt  = state;
      a_ack_nxt  = a_ack_q;
      z_stb_nxt  = z_stb_q;
      ca_stb_nxt = ca_stb_q;
      cz_ack_nxt = cz_ack_q;
      grant_nxt  = grant_q;
      rr_ptr_nxt = rr_ptr_q;
      a_nxt      = a_q;
      z_nxt      = z_q;
      req_z_nxt  = req_z_q;
      unique case (state)
         ARB: begin
            if (pick_any) begin
               grant_nxt = pick_idx;
               a_ack_nxt = NUM_REQ'(1) << pick_idx;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // ack stays high if the requester drops stb before the transfer
            if (req_a_stb[grant_q] && a_ack_q[grant_q]) begin
               a_nxt     = req_a[32'(grant_q)*WORD_W +: WORD_W];
               a_ack_nxt = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (ca_stb_q && conv_a_ack) begin
               ca_stb_nxt = 1'b0;
               state_nxt  = WAIT_Z;
            end else begin
               ca_stb_nxt = 1'b1;
            end
         end
         WAIT_Z: begin
            if (cz_ack_q && conv_z_stb) begin
               z_nxt      = conv_z;
               cz_ack_nxt = 1'b0;
               state_nxt  = PUT_Z;
            end else begin
               cz_ack_nxt = 1'b1;
            end
         end
         PUT_Z: begin
            if (z_stb_q[grant_q] && req_z_ack[grant_q]) begin
               z_stb_nxt  = '0;
               rr_ptr_nxt = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               state_nxt  = ARB;
            end else begin
               z_stb_nxt = NUM_REQ'(1) << grant_q;
               req_z_nxt = z_q;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ARB;
         a_ack_q  <= '0;
         z_stb_q  <= '0;
         ca_stb_q <= 1'b0;
         cz_ack_q <= 1'b0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         a_q      <= '0;
         z_q      <= '0;
         req_z_q  <= '0;
      end else begin
         state    <= state_nxt;
         a_ack_q  <= a_ack_nxt;
         z_stb_q  <= z_stb_nxt;
         ca_stb_q <= ca_stb_nxt;
         cz_ack_q <= cz_ack_nxt;
         grant_q  <= grant_nxt;
         rr_ptr_q <= rr_ptr_nxt;
         busy_q   <= (state_nxt != ARB);
         a_q      <= a_nxt;
         z_q      <= z_nxt;
         req_z_q  <= req_z_nxt;
      end
   end

   assign req_a_ack  = a_ack_q;
   assign req_z_stb  = z_stb_q;
   assign req_z      = req_z_q;
   assign conv_a     = a_q;
   assign conv_a_stb = ca_stb_q;
   assign conv_z_ack = cz_ack_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;

endmodule

// File: doc/double_to_int_arbiter.md
Name: double_to_int_arbiter

Overview:
Round-robin arbiter that shares one double_to_int converter between NUM_REQ requesters. Each requester port uses the codebase's stb/ack handshake. The block sequences one conversion at a time: it accepts an operand, forwards it to the converter, collects the result, and returns it to the requester that won arbitration. It sits between the requester cores and a single converter instance.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
IDX_W, derived as clog2(NUM_REQ) with minimum 1, width of the grant index

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low
req_a  input  64*NUM_REQ  operands packed; requester i uses bits [64i+63:64i]
req_a_stb  input  NUM_REQ  operand valid, one bit per requester
req_a_ack  output  NUM_REQ  operand accept; registered, at most one bit high
req_z  output  64  result bus, broadcast to all requesters
req_z_stb  output  NUM_REQ  result valid; registered, one-hot to the granted requester
req_z_ack  input  NUM_REQ  result accept
conv_a  output  64  operand to converter input_a
conv_a_stb  output  1  to converter input_a_stb
conv_a_ack  input  1  from converter input_a_ack
conv_z  input  64  from converter output_z
conv_z_stb  input  1  from converter output_z_stb
conv_z_ack  output  1  to converter output_z_ack
grant_id  output  IDX_W  index of the current or last granted requester
busy  output  1  high in every state except ARB

Behaviour:
- Transfer rule: a transfer occurs on a posedge where stb and ack are both high. All stb/ack outputs are registered.
- Reset: when rst==0 at a posedge:
  - state <= ARB
  - req_a_ack, req_z_stb, conv_a_stb, conv_z_ack, grant_id, busy, rr_ptr all <= 0
  - Reset wins over any transfer in the same cycle. A reset mid-operation abandons the transaction and no result is delivered.
  - The top level drives the converter's active-high rst from ~rst, so both reset together.
- ARB:
  - If any req_a_stb is high, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - grant_id <= winner; req_a_ack <= one-hot(winner); go to GRANT.
  - If no stb is high, stay in ARB.
- GRANT:
  - On req_a_stb[grant_id] && req_a_ack[grant_id]: latch a <= req_a slice, req_a_ack <= 0, go to SEND.
  - Requesters must hold stb until acked. If stb drops, stay in GRANT with ack held high.
- SEND:
  - conv_a_stb <= 1; conv_a = latched a.
  - On conv_a_stb && conv_a_ack: conv_a_stb <= 0, go to WAIT_Z.
- WAIT_Z:
  - conv_z_ack <= 1.
  - On conv_z_stb && conv_z_ack: z <= conv_z, conv_z_ack <= 0, go to PUT_Z.
- PUT_Z:
  - req_z_stb[grant_id] <= 1; req_z <= z.
  - On req_z_stb[grant_id] && req_z_ack[grant_id]: req_z_stb <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to ARB.
- Latency: the first req_a_ack rises 1 cycle after stb is sampled in ARB. The arbiter adds 2 cycles before conv_a_stb rises. After a result is accepted, the next grant is possible 1 cycle after returning to ARB.
- Fairness: the just-served requester has lowest priority in the next ARB.
- Re-requests: a requester holding stb during PUT_Z is not acked until after its result is accepted.
- Simultaneous requests are resolved only in ARB. Requests arriving in any other state wait.
- NUM_REQ=1: rr_ptr and grant_id stay at 0.
- req_a_ack and req_z_stb are never high for a non-granted index. ack and stb are never high at the same time for the same requester on the a-side and z-side.

Decomposition:
- Package double_to_int_arb_pkg:
  - state encoding ARB=0, GRANT=1, SEND=2, WAIT_Z=3, PUT_Z=4 (3 bits)
  - constant WORD_W=64
  - constant OVERFLOW_Z = 64'h8000000000000000 (for bench checks)
- Sub-module double_to_int_rr_pick: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any.

Test Plan:
- Requester 0 sends 0x3FF0000000000000 (1.0) -> req_z=0x0000000000000001 with req_z_stb[0] only; grant_id=0.
- Requesters 0..3 all assert stb together with 0xC004000000000000 (-2.5), 0x0 (0.0), 0x4024000000000000 (10.0), 0x7E37E43C8800759C (1e300) -> served in order 0,1,2,3 with results 0xFFFFFFFFFFFFFFFE, 0, 0xA, 0x8000000000000000.
- Requester 2 is served, then requesters 1 and 2 request together -> requester 1 is granted next (rr_ptr=3 wraps to 1).
- Requester holds req_z_ack low for 10 cycles in PUT_Z -> req_z_stb stays high and req_z is stable; no new req_a_ack is issued.
- Converter delays conv_a_ack by 5 cycles -> conv_a_stb is held and conv_a is stable; no duplicate transfer.
- rst=0 for 1 cycle during WAIT_Z -> next cycle all outputs are 0 and state is ARB; a fresh request then completes normally.
